spi_master: RTL and testbench



---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_master_if.sv | 23 ++
 rtl/spi_half_period_cnt.sv | 26 ++
 rtl/spi_master.sv | 129 ++++++++++++
 tb/tb_spi_master.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    NEXT,
    HOLD,
    GAP
  } spi_mst_state_t;

  localparam int SPI_BITS    = 8;
  localparam int SPI_CLK_DIV = 4;

endpackage

// File: rtl/spi_master_if.sv
// Host-side byte stream of the SPI master: tx ready/valid with a last flag, rx pulse.
interface spi_master_if;
  import spi_pkg::*;

  logic [SPI_BITS-1:0] tx_data;
  logic                tx_last;
  logic                tx_valid;
  logic                tx_ready;
  logic [SPI_BITS-1:0] rx_data;
  logic                rx_valid;

  // master = host logic feeding bytes, slave = the SPI engine consuming them
  modport master (
    output tx_data, tx_last, tx_valid,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_last, tx_valid,
    output tx_ready, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_half_period_cnt.sv
// Loadable down-counter timing one SCLK half-period; expire is high while the count is zero.
module spi_half_period_cnt #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_load_val,
  output logic             o_expire
);

  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/spi_master.sv
// SPI mode 0 master, MSB first; one CS_n-low frame carries bytes until one is flagged last.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV,
  parameter int DIV_W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.slave  host,
  output logic         sclk,
  output logic         mosi,
  input  logic         miso,
  output logic         cs_n,
  output logic         busy
);

  spi_mst_state_t      r_state;
  logic [1:0]          r_miso_sync;
  logic [SPI_BITS-2:0] r_shift_tx;
  logic [SPI_BITS-1:0] r_shift_rx;
  logic [SPI_BITS-1:0] r_rx_data;
  logic [2:0]          r_bit_cnt;
  logic                r_last;
  logic                r_sclk;
  logic                r_mosi;
  logic                r_cs_n;
  logic                r_rx_valid;

  logic w_tx_ready;
  logic w_accept;
  logic w_expire;
  logic w_load;

  assign w_tx_ready = (r_state == IDLE) || (r_state == NEXT);
  assign w_accept   = host.tx_valid && w_tx_ready;
  // Reload on every state/phase change; the timed states leave only on expire.
  assign w_load     = w_accept ||
                      (w_expire && (r_state inside {SETUP, LOW, HIGH, HOLD, GAP}));

  spi_half_period_cnt #(.DIV_W(DIV_W)) u_half_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (DIV_W'(CLK_DIV - 1)),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miso_sync <= 2'b00;
    end else begin
      r_miso_sync <= {r_miso_sync[0], miso};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shift_tx <= '0;
      r_shift_rx <= '0;
      r_rx_data  <= '0;
      r_bit_cnt  <= '0;
      r_last     <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        IDLE, NEXT: begin
          if (w_accept) begin
            r_shift_tx <= host.tx_data[SPI_BITS-2:0];
            r_last     <= host.tx_last;
            r_bit_cnt  <= '0;
            r_cs_n     <= 1'b0;
            r_mosi     <= host.tx_data[SPI_BITS-1];
            r_state    <= SETUP;
          end
        end
        SETUP, LOW: begin
          if (w_expire) begin
            r_sclk     <= 1'b1;
            r_shift_rx <= {r_shift_rx[SPI_BITS-2:0], r_miso_sync[1]};
            r_state    <= HIGH;
          end
        end
        HIGH: begin
          if (w_expire) begin
            r_sclk <= 1'b0;
            if (r_bit_cnt == 3'(SPI_BITS - 1)) begin
              r_rx_data  <= r_shift_rx;
              r_rx_valid <= 1'b1;
              r_state    <= r_last ? HOLD : NEXT;
            end else begin
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              r_mosi     <= r_shift_tx[SPI_BITS-2];
              r_shift_tx <= {r_shift_tx[SPI_BITS-3:0], 1'b0};
              r_state    <= LOW;
            end
          end
        end
        HOLD: begin
          if (w_expire) begin
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
            r_state <= GAP;
          end
        end
        GAP: begin
          if (w_expire) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign host.tx_ready = w_tx_ready;
  assign host.rx_data  = r_rx_data;
  assign host.rx_valid = r_rx_valid;
  assign sclk          = r_sclk;
  assign mosi          = r_mosi;
  assign cs_n          = r_cs_n;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: random frames against a byte-level model and a bit-level slave.
`timescale 1ns/1ps
module tb_spi_master;
  import spi_pkg::*;

  localparam int D = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sclk, mosi, miso, cs_n, busy;

  spi_master_if bus();

  spi_master #(.CLK_DIV(D), .DIV_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (bus),
    .sclk  (sclk),
    .mosi  (mosi),
    .miso  (miso),
    .cs_n  (cs_n),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] slave_q[$];

  // Slave model: presents the MSB of its byte while idle, shifts on every SCLK fall.
  bit         loopback   = 1'b1;
  logic [7:0] slave_byte = 8'h00;
  int         sbit       = 0;
  bit         have       = 1'b0;
  logic       s_prev     = 1'b0;
  logic       slave_bit;

  assign slave_bit = slave_byte[3'(7 - sbit)];
  assign miso      = loopback ? mosi : slave_bit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  always @(negedge clk) begin
    if (have && s_prev && !sclk) begin
      if (sbit == 7) begin
        have = 1'b0;
        sbit = 0;
      end else begin
        sbit++;
      end
    end
    if (!have && slave_q.size() > 0) begin
      slave_byte = slave_q.pop_front();
      sbit       = 0;
      have       = 1'b1;
    end
    s_prev = sclk;
  end

  // Monitor: scoreboard pops on rx_valid; also counts edges and guards mosi while sclk is high.
  int   rise_cnt     = 0;
  int   csn_rise_cnt = 0;
  logic p_sclk = 1'b0, p_csn = 1'b1, p_mosi = 1'b0, p_rst = 1'b0;

  always @(negedge clk) begin
    if (rst_n && p_rst) begin
      if (bus.rx_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rx_unexpected: got %0h expected no rx_valid", bus.rx_data);
        end else begin
          chk("rx_data", bus.rx_data, exp_q.pop_front());
        end
      end
      if (sclk && !p_sclk) rise_cnt++;
      if (cs_n && !p_csn)  csn_rise_cnt++;
      if (sclk) chk("mosi_stable_sclk_high", mosi, p_mosi);
    end
    p_sclk = sclk;
    p_csn  = cs_n;
    p_mosi = mosi;
    p_rst  = rst_n;
  end

  // Called on a negedge; returns on the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] d, input logic [7:0] sresp, input bit last,
                           input bit keep_valid, input bit expect_rx);
    int guard;
    logic [7:0] rx;
    rx = loopback ? d : sresp;
    if (!loopback) slave_q.push_back(sresp);
    if (expect_rx) exp_q.push_back(rx);
    bus.tx_data  = d;
    bus.tx_last  = last;
    bus.tx_valid = 1'b1;
    guard = 0;
    while (!bus.tx_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) timeout_fail("accept");
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) bus.tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) timeout_fail("wait_idle");
  endtask

  int         t_cs, t_rx, t_csh, t_rdy, nr;
  int         rise_t[8];
  logic       rise_m[8];
  logic       prev;
  logic [7:0] pat;
  int         base_r, base_c, nb, gap;
  bit         ok, last;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tx_data  = 8'h00;
    bus.tx_last  = 1'b0;
    bus.tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_tx_ready", bus.tx_ready, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte loopback with exact edge timing.
    loopback = 1'b1;
    pat = 8'hA5;
    bus.tx_data = pat; bus.tx_last = 1'b1; bus.tx_valid = 1'b1;
    exp_q.push_back(pat);
    chk("idle_tx_ready", bus.tx_ready, 1);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    t_cs = -1; t_rx = -1; t_csh = -1; t_rdy = -1; nr = 0; prev = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (t_cs < 0 && !cs_n) t_cs = c;
      if (sclk && !prev) begin
        if (nr < 8) begin
          rise_t[nr] = c;
          rise_m[nr] = mosi;
        end
        nr++;
      end
      if (t_rx < 0 && bus.rx_valid) t_rx = c;
      if (t_cs >= 0 && t_csh < 0 && cs_n) t_csh = c;
      if (t_cs >= 0 && t_rdy < 0 && bus.tx_ready) t_rdy = c;
      prev = sclk;
      @(negedge clk);
    end
    chk("cs_n_fall_cycle", t_cs, 0);
    chk("sclk_rise_count", nr, 8);
    for (int k = 0; k < 8; k++) begin
      chk("sclk_rise_cycle", rise_t[k], t_cs + D + 2 * D * k);
      chk("mosi_bit", rise_m[k], pat[7 - k]);
    end
    chk("rx_valid_cycle", t_rx, t_cs + 16 * D);
    chk("cs_n_rise_cycle", t_csh, t_cs + 17 * D);
    chk("tx_ready_cycle", t_rdy, t_cs + 18 * D);

    // Three-byte frame with tx_valid held high.
    base_r = rise_cnt; base_c = csn_rise_cnt;
    send_byte(8'h01, 8'h00, 1'b0, 1'b1, 1'b1);
    send_byte(8'h80, 8'h00, 1'b0, 1'b1, 1'b1);
    send_byte(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_idle();
    chk("frame3_rises", rise_cnt - base_r, 24);
    chk("frame3_cs_rises", csn_rise_cnt - base_c, 1);

    // NEXT stall for 50 cycles.
    base_r = rise_cnt; base_c = csn_rise_cnt;
    send_byte(8'h6E, 8'h00, 1'b0, 1'b0, 1'b1);
    gap = 0;
    while (!bus.tx_ready && gap < 500) begin
      @(negedge clk);
      gap++;
    end
    if (gap >= 500) timeout_fail("reach_next");
    ok = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (cs_n || sclk || !busy) ok = 1'b0;
      @(negedge clk);
    end
    chk("stall_cs_low_sclk_low", ok, 1);
    send_byte(8'h93, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_idle();
    chk("stall_rises", rise_cnt - base_r, 16);
    chk("stall_cs_rises", csn_rise_cnt - base_c, 1);

    // Slave returns 0x3C while 0xC3 goes out.
    loopback = 1'b0;
    send_byte(8'hC3, 8'h3C, 1'b1, 1'b0, 1'b1);
    wait_idle();
    loopback = 1'b1;

    // Reset during bit 4 aborts without rx_valid.
    base_r = rise_cnt;
    send_byte(8'h96, 8'h00, 1'b1, 1'b0, 1'b0);
    gap = 0;
    while (rise_cnt - base_r < 5 && gap < 500) begin
      @(negedge clk);
      gap++;
    end
    if (gap >= 500) timeout_fail("reach_bit4");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", cs_n, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_mosi", mosi, 0);
    chk("abort_busy", busy, 0);
    ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.rx_valid) ok = 1'b0;
    end
    chk("abort_no_rx_valid", ok, 1);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h5A, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_idle();

    // tx_valid pulses while busy are ignored.
    base_c = csn_rise_cnt;
    send_byte(8'h37, 8'h00, 1'b1, 1'b0, 1'b1);
    gap = 0;
    while (busy && gap < 500) begin
      if ($urandom_range(2) == 0) begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'($urandom);
        bus.tx_last  = 1'($urandom);
        chk("ready_low_while_busy", bus.tx_ready, 0);
      end else begin
        bus.tx_valid = 1'b0;
      end
      @(negedge clk);
      gap++;
    end
    bus.tx_valid = 1'b0;
    if (gap >= 500) timeout_fail("pulse_frame");
    repeat (10) @(negedge clk);
    chk("no_stray_frame", busy, 0);
    chk("pulse_cs_rises", csn_rise_cnt - base_c, 1);

    // Random frames: mixed loopback/slave, 1-3 bytes, optional stalls.
    for (int f = 0; f < 8; f++) begin
      loopback = 1'($urandom);
      nb = 1 + $urandom_range(2);
      base_r = rise_cnt; base_c = csn_rise_cnt;
      for (int b = 0; b < nb; b++) begin
        last = (b == nb - 1);
        gap  = last ? 0 : $urandom_range(20);
        send_byte(8'($urandom), 8'($urandom), last, !last && gap == 0, 1'b1);
        repeat (gap) @(negedge clk);
      end
      wait_idle();
      chk("rand_rises", rise_cnt - base_r, 8 * nb);
      chk("rand_cs_rises", csn_rise_cnt - base_c, 1);
    end
    loopback = 1'b1;

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("slave_drained", slave_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
